// File: rtl/systolic_mm_ctrl.sv
// Job controller and skew feeder for an M x K * K x P systolic multiply.
// It latches both operand matrices on start and pulses an accumulator clear.
// It then streams diagonally skewed rows and columns, waits for the PE pipeline,
// and reports completion. Every output is registered and is decoded from the
// next state, so the outputs line up with the state register.
module systolic_mm_ctrl #(
    parameter int BW     = 16,
    parameter int M      = 3,
    parameter int N_MAX  = 4,
    parameter int P      = 5,
    parameter int PE_LAT = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                iStart,
    input  logic [$clog2(N_MAX+1)-1:0]          iKLen,
    input  logic [M-1:0][N_MAX-1:0][BW-1:0]     iRow,
    input  logic [N_MAX-1:0][P-1:0][BW-1:0]     iCol,
    output logic [M-1:0][BW-1:0]                oRow,
    output logic [P-1:0][BW-1:0]                oCol,
    output logic                                oClrAcc,
    output logic                                oBusy,
    output logic                                oDone,
    output logic                                oErr
);

    localparam int KW = $clog2(N_MAX + 1);
    localparam int CW = $clog2(N_MAX + M + P + PE_LAT) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                         state, nState;
    logic [CW-1:0]                      cnt, nCnt, tFeed;
    logic [KW-1:0]                      kQ;
    logic [M-1:0][N_MAX-1:0][BW-1:0]    aQ;
    logic [N_MAX-1:0][P-1:0][BW-1:0]    bQ;
    logic [M-1:0][BW-1:0]               nRow;
    logic [P-1:0][BW-1:0]               nCol;
    logic                               kLegal, latchJob, errStart;

    assign kLegal   = (iKLen != '0) && (iKLen <= KW'(N_MAX));
    assign latchJob = (state == IDLE) && iStart && kLegal;
    assign errStart = (state == IDLE) && iStart && !kLegal;
    // Feed window length. It covers the skew of both edges plus the inner dimension.
    assign tFeed    = CW'(kQ) + CW'(M + P - 2);

    // Next-state logic. The counter runs through FEED and DRAIN without restarting.
    always_comb begin
        nState = state;
        nCnt   = cnt;
        case (state)
            IDLE: begin
                nCnt = '0;
                if (iStart) nState = kLegal ? CLR : DONE;
            end
            CLR: begin
                nState = FEED;
                nCnt   = '0;
            end
            FEED: begin
                nCnt = cnt + ONE;
                if (cnt == tFeed - ONE) nState = (PE_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                nCnt = cnt + ONE;
                if (cnt == tFeed + CW'(PE_LAT) - ONE) nState = DONE;
            end
            DONE:    nState = IDLE;
            default: nState = IDLE;
        endcase
    end

    // Skewed feed for the next cycle. Row i lags by i cycles and column j lags by j cycles.
    always_comb begin
        nRow = '0;
        nCol = '0;
        if (nState == FEED) begin
            for (int i = 0; i < M; i++)
                for (int k = 0; k < N_MAX; k++)
                    if (nCnt == CW'(i + k) && KW'(k) < kQ) nRow[i] = aQ[i][k];
            for (int j = 0; j < P; j++)
                for (int k = 0; k < N_MAX; k++)
                    if (nCnt == CW'(j + k) && KW'(k) < kQ) nCol[j] = bQ[k][j];
        end
    end

    // State, counter and operand latches. Operands are captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            kQ    <= '0;
            aQ    <= '0;
            bQ    <= '0;
        end else begin
            state <= nState;
            cnt   <= nCnt;
            if (latchJob) begin
                kQ <= iKLen;
                aQ <= iRow;
                bQ <= iCol;
            end
        end
    end

    // Registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oRow    <= '0;
            oCol    <= '0;
            oClrAcc <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
        end else begin
            oRow    <= nRow;
            oCol    <= nCol;
            oClrAcc <= (nState == CLR);
            oBusy   <= (nState != IDLE);
            oDone   <= (nState == DONE);
            oErr    <= errStart;
        end
    end

endmodule
